stage_memory: RTL

Memory stage of the vectorial ASIP pipeline. It sits directly after the EX/MEM pipe register and consumes its control bundle and execute-result vector. It performs scalar (1-word) and vector (multi-word) loads and stores against a 16-bit synchronous data memory, stalling upstream while a multi-beat access is in flight. It presents a registered result bundle to the MEM/WB pipe.

---
 rtl/stage_memory.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/stage_memory.sv
// Memory stage of the vector ASIP pipeline.
// Performs scalar and multi-beat vector loads/stores against a synchronous
// word memory, stalls upstream during multi-beat accesses, and registers the
// writeback bundle for the MEM/WB pipe.
module stage_memory #(
  parameter int unsigned RegisterSize = 8,
  parameter int unsigned VectorSize   = 4,
  parameter int unsigned WordWidth    = 16,
  parameter int unsigned AddrWidth    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic                               in_mem_write,
  input  logic [1:0]                         in_wb_sel,
  input  logic [3:0]                         in_reg,
  input  logic [RegisterSize-1:0]            in_imm,
  input  logic                               in_wr_sc,
  input  logic                               in_wr_vec,
  input  logic                               in_vector,
  input  logic [AddrWidth-1:0]               in_addr,
  input  logic [VectorSize*RegisterSize-1:0] in_data,
  output logic                               stall,
  output logic [AddrWidth-1:0]               mem_addr,
  output logic [WordWidth-1:0]               mem_wdata,
  output logic                               mem_we,
  input  logic [WordWidth-1:0]               mem_rdata,
  output logic                               out_valid,
  output logic [1:0]                         out_wb_sel,
  output logic [3:0]                         out_reg,
  output logic [RegisterSize-1:0]            out_imm,
  output logic                               out_wr_sc,
  output logic                               out_wr_vec,
  output logic [VectorSize*RegisterSize-1:0] out_data
);

  localparam int unsigned Lpw   = WordWidth / RegisterSize;
  localparam int unsigned Beats = VectorSize / Lpw;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned DataW = VectorSize * RegisterSize;

  typedef enum logic [1:0] {StIdle, StBeat, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  // Latched request for the access in flight
  logic                    store_q, store_d;
  logic                    vector_q, vector_d;
  logic [1:0]              wb_sel_q, wb_sel_d;
  logic [3:0]              reg_q, reg_d;
  logic [RegisterSize-1:0] imm_q, imm_d;
  logic                    wr_sc_q, wr_sc_d;
  logic                    wr_vec_q, wr_vec_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  // Store data, or load capture buffer (cleared on accept of a load)
  logic [DataW-1:0]        data_q, data_d;
  // Registered writeback bundle
  logic                    out_valid_q, out_valid_d;
  logic [1:0]              out_wb_sel_q, out_wb_sel_d;
  logic [3:0]              out_reg_q, out_reg_d;
  logic [RegisterSize-1:0] out_imm_q, out_imm_d;
  logic                    out_wr_sc_q, out_wr_sc_d;
  logic                    out_wr_vec_q, out_wr_vec_d;
  logic [DataW-1:0]        out_data_q, out_data_d;

  logic             is_store, is_load, last_beat, cap_en, load_out;
  logic [BeatW-1:0] cap_word;

  assign is_store = in_mem_write;
  assign is_load  = !in_mem_write && (in_wb_sel == 2'b01);

  // Next-state, memory bus and writeback bundle decode
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    store_d      = store_q;
    vector_d     = vector_q;
    wb_sel_d     = wb_sel_q;
    reg_d        = reg_q;
    imm_d        = imm_q;
    wr_sc_d      = wr_sc_q;
    wr_vec_d     = wr_vec_q;
    addr_d       = addr_q;
    data_d       = data_q;
    out_valid_d  = 1'b0;
    out_wb_sel_d = out_wb_sel_q;
    out_reg_d    = out_reg_q;
    out_imm_d    = out_imm_q;
    out_wr_sc_d  = out_wr_sc_q;
    out_wr_vec_d = out_wr_vec_q;
    out_data_d   = out_data_q;
    stall        = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_we       = 1'b0;
    last_beat    = 1'b0;
    cap_en       = 1'b0;
    cap_word     = '0;
    load_out     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (in_valid) begin
          if (is_store || is_load) begin
            store_d  = is_store;
            vector_d = in_vector;
            wb_sel_d = in_wb_sel;
            reg_d    = in_reg;
            imm_d    = in_imm;
            wr_sc_d  = in_wr_sc;
            wr_vec_d = in_wr_vec;
            addr_d   = in_addr;
            data_d   = is_store ? in_data : '0;
            beat_d   = '0;
            state_d  = StBeat;
          end else begin
            out_valid_d  = 1'b1;
            out_wb_sel_d = in_wb_sel;
            out_reg_d    = in_reg;
            out_imm_d    = in_imm;
            out_wr_sc_d  = in_wr_sc;
            out_wr_vec_d = in_wr_vec;
            out_data_d   = in_data;
          end
        end
      end
      StBeat: begin
        stall    = 1'b1;
        mem_addr = addr_q + AddrWidth'(beat_q);
        if (store_q) begin
          mem_we = 1'b1;
          if (vector_q) begin
            for (int unsigned w = 0; w < Beats; w++) begin
              if (beat_q == BeatW'(w)) mem_wdata = data_q[w*WordWidth +: WordWidth];
            end
          end else begin
            mem_wdata[RegisterSize-1:0] = data_q[RegisterSize-1:0];
          end
        end else if (beat_q != '0) begin
          // Read data lags the address by one cycle: capture the previous beat's word
          cap_en   = 1'b1;
          cap_word = beat_q - BeatW'(1);
        end
        last_beat = !vector_q || (beat_q == BeatW'(Beats - 1));
        if (last_beat) begin
          if (store_q) begin
            state_d  = StDone;
            load_out = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      StWait: begin
        stall = 1'b1;
        if (vector_q) begin
          cap_en   = 1'b1;
          cap_word = beat_q;
        end else begin
          data_d[RegisterSize-1:0] = mem_rdata[RegisterSize-1:0];
        end
        state_d  = StDone;
        load_out = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (cap_en) begin
      for (int unsigned w = 0; w < Beats; w++) begin
        if (cap_word == BeatW'(w)) data_d[w*WordWidth +: WordWidth] = mem_rdata;
      end
    end

    if (load_out) begin
      out_valid_d  = 1'b1;
      out_wb_sel_d = wb_sel_q;
      out_reg_d    = reg_q;
      out_imm_d    = imm_q;
      out_wr_sc_d  = wr_sc_q & ~store_q;
      out_wr_vec_d = wr_vec_q & ~store_q;
      out_data_d   = data_d;
    end
  end

  // State, request latch and writeback registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      store_q      <= 1'b0;
      vector_q     <= 1'b0;
      wb_sel_q     <= '0;
      reg_q        <= '0;
      imm_q        <= '0;
      wr_sc_q      <= 1'b0;
      wr_vec_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      out_wb_sel_q <= '0;
      out_reg_q    <= '0;
      out_imm_q    <= '0;
      out_wr_sc_q  <= 1'b0;
      out_wr_vec_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      store_q      <= store_d;
      vector_q     <= vector_d;
      wb_sel_q     <= wb_sel_d;
      reg_q        <= reg_d;
      imm_q        <= imm_d;
      wr_sc_q      <= wr_sc_d;
      wr_vec_q     <= wr_vec_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      out_wb_sel_q <= out_wb_sel_d;
      out_reg_q    <= out_reg_d;
      out_imm_q    <= out_imm_d;
      out_wr_sc_q  <= out_wr_sc_d;
      out_wr_vec_q <= out_wr_vec_d;
      out_data_q   <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_wb_sel = out_wb_sel_q;
  assign out_reg    = out_reg_q;
  assign out_imm    = out_imm_q;
  assign out_wr_sc  = out_wr_sc_q;
  assign out_wr_vec = out_wr_vec_q;
  assign out_data   = out_data_q;

endmodule
